// File: rtl/phys_reg_freelist.sv
// Free list of physical register tags for rename: a circular tag array with wrap-bit
// head/tail pointers, a one-deep allocation checkpoint, and a post-reset init fill.
module phys_reg_freelist #(
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned TAG_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ready,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    input  logic             ckpt_save,
    input  logic             ckpt_restore,
    output logic [TAG_W:0]   free_count,
    output logic             overflow_err
);

    localparam int unsigned PTR_W = TAG_W + 1;
    localparam int unsigned CAP   = PHYS_REGS - ARCH_REGS;

    localparam logic [PTR_W-1:0] CAP_CNT   = PTR_W'(CAP);
    localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(ARCH_REGS);
    localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(PHYS_REGS - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] ckpt_head;
    logic [TAG_W-1:0] init_tag;
    logic [TAG_W-1:0] mem [PHYS_REGS];

    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] head_adv;
    logic             in_init;
    logic             full;
    logic             grant;
    logic             free_ok;
    logic             free_drop;
    logic             mem_we;
    logic [TAG_W-1:0] mem_wdata;

    // Occupancy and handshake terms; wrap bit makes tail - head exact for full vs empty.
    assign count       = tail - head;
    assign in_init     = (state == S_INIT);
    assign ready       = (state == S_READY);
    assign full        = (count == CAP_CNT);
    assign alloc_valid = ready & (count != '0) & ~ckpt_restore;
    assign grant       = alloc_req & alloc_valid;
    assign free_ok     = ready & free_valid & ~full;
    assign free_drop   = free_valid & (in_init | full);
    assign head_adv    = head + PTR_W'(grant);
    assign alloc_tag   = mem[head[TAG_W-1:0]];
    assign free_count  = count;

    // The tail slot is written by the init fill, or by retire once ready.
    assign mem_we    = in_init | free_ok;
    assign mem_wdata = in_init ? init_tag : free_tag;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[tail[TAG_W-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_INIT;
            head         <= '0;
            tail         <= '0;
            ckpt_head    <= '0;
            init_tag     <= FIRST_TAG;
            overflow_err <= 1'b0;
        end else begin
            if (free_drop) begin
                overflow_err <= 1'b1;
            end
            case (state)
                S_INIT: begin
                    tail     <= tail + PTR_W'(1);
                    init_tag <= init_tag + TAG_W'(1);
                    if (init_tag == LAST_TAG) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    // Restore rewinds head and suppresses both the grant and any save.
                    if (ckpt_restore) begin
                        head <= ckpt_head;
                    end else begin
                        head <= head_adv;
                        if (ckpt_save) begin
                            ckpt_head <= head_adv;
                        end
                    end
                    if (free_ok) begin
                        tail <= tail + PTR_W'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Self-checking bench for phys_reg_freelist: directed sequences, a vector table for
// checkpoint/full behaviour, and random traffic against a queue-based reference model.
module tb_phys_reg_freelist;

    localparam int unsigned PHYS_REGS = 64;
    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned TAG_W     = 6;
    localparam int unsigned CAP       = PHYS_REGS - ARCH_REGS;

    typedef logic [TAG_W-1:0] tag_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ready;
    logic           alloc_req = 1'b0;
    logic           alloc_valid;
    tag_t           alloc_tag;
    logic           free_valid = 1'b0;
    tag_t           free_tag = '0;
    logic           ckpt_save = 1'b0;
    logic           ckpt_restore = 1'b0;
    logic [TAG_W:0] free_count;
    logic           overflow_err;

    int n_checks = 0;
    int n_fail   = 0;

    phys_reg_freelist #(
        .PHYS_REGS(PHYS_REGS),
        .ARCH_REGS(ARCH_REGS),
        .TAG_W    (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ready       (ready),
        .alloc_req   (alloc_req),
        .alloc_valid (alloc_valid),
        .alloc_tag   (alloc_tag),
        .free_valid  (free_valid),
        .free_tag    (free_tag),
        .ckpt_save   (ckpt_save),
        .ckpt_restore(ckpt_restore),
        .free_count  (free_count),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic f, input tag_t t, input logic s, input logic x);
        @(negedge clk);
        alloc_req    = r;
        free_valid   = f;
        free_tag     = t;
        ckpt_save    = s;
        ckpt_restore = x;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag_name);
        check({tag_name, "_ready"}, int'(ready), 0);
        check({tag_name, "_valid"}, int'(alloc_valid), 0);
        check({tag_name, "_count"}, int'(free_count), 0);
        check({tag_name, "_ovf"}, int'(overflow_err), 0);
    endtask

    // Reset, release, and time the init fill; optionally inject a free mid-init.
    task automatic reset_and_wait(input logic inject, input int exp_ovf);
        int cyc;
        @(negedge clk);
        rst_n = 1'b0;
        alloc_req = 1'b0; free_valid = 1'b0; free_tag = '0;
        ckpt_save = 1'b0; ckpt_restore = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_ready_low", int'(ready), 0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            cyc = i;
            if (inject && i == 5) begin
                free_valid = 1'b1;
                free_tag   = tag_t'(9);
            end else begin
                free_valid = 1'b0;
            end
            if (ready) break;
        end
        free_valid = 1'b0;
        check("ready_latency", cyc, int'(CAP));
        check("ready_count", int'(free_count), int'(CAP));
        check("ready_head_tag", int'(alloc_tag), int'(ARCH_REGS));
        check("ready_ovf", int'(overflow_err), exp_ovf);
    endtask

    typedef struct {
        logic req;
        logic fv;
        tag_t ft;
        logic sv;
        logic rs;
        logic e_valid;
        logic chk_tag;
        tag_t e_tag;
        int   e_count;
        logic e_ovf;
    } vec_t;

    vec_t tbl[17];

    // Reference model state: free tags in order, plus tags handed out since the checkpoint.
    tag_t q[$];
    tag_t spec[$];
    logic m_ovf;

    initial begin
        // Checkpoint, restore, full-drop and restore-beats-save vectors from a fresh fill.
        tbl[0]  = '{1'b1, 1'b0, tag_t'(0),  1'b1, 1'b0, 1'b1, 1'b1, tag_t'(32), 32, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(33), 31, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(34), 30, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(35), 29, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b1, 1'b0, 1'b0, tag_t'(0),  28, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(33), 31, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, tag_t'(40), 1'b0, 1'b0, 1'b1, 1'b1, tag_t'(33), 31, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(34), 31, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, tag_t'(7),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(34), 31, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, tag_t'(8),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(34), 32, 1'b0};
        tbl[10] = '{1'b0, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(34), 32, 1'b1};
        tbl[11] = '{1'b1, 1'b0, tag_t'(0),  1'b1, 1'b0, 1'b1, 1'b1, tag_t'(34), 32, 1'b1};
        tbl[12] = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(35), 31, 1'b1};
        tbl[13] = '{1'b1, 1'b0, tag_t'(0),  1'b1, 1'b1, 1'b0, 1'b0, tag_t'(0),  30, 1'b1};
        tbl[14] = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(35), 31, 1'b1};
        tbl[15] = '{1'b1, 1'b0, tag_t'(0),  1'b0, 1'b1, 1'b0, 1'b0, tag_t'(0),  30, 1'b1};
        tbl[16] = '{1'b0, 1'b0, tag_t'(0),  1'b0, 1'b0, 1'b1, 1'b1, tag_t'(35), 31, 1'b1};

        // Init timing, then drain past empty.
        reset_and_wait(1'b0, 0);
        for (int k = 0; k < 34; k++) begin
            apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check("drain_valid", int'(alloc_valid), (k < 32) ? 1 : 0);
            if (k < 32) check("drain_tag", int'(alloc_tag), 32 + k);
            tick();
        end
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("drain_count", int'(free_count), 0);

        // No bypass: a free into an empty list cannot serve the same-cycle request.
        apply(1'b1, 1'b1, tag_t'(5), 1'b0, 1'b0);
        check("nobypass_valid", int'(alloc_valid), 0);
        tick();
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("refill_valid", int'(alloc_valid), 1);
        check("refill_tag", int'(alloc_tag), 5);
        check("refill_count", int'(free_count), 1);

        // Full list: grant plus free drops the free, count falls to 31.
        reset_and_wait(1'b0, 0);
        apply(1'b1, 1'b1, tag_t'(7), 1'b0, 1'b0);
        check("full_pre_count", int'(free_count), 32);
        tick();
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("full_drop_count", int'(free_count), 31);
        check("full_drop_ovf", int'(overflow_err), 1);
        for (int k = 0; k < 31; k++) begin
            apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check("full_alloc_tag", int'(alloc_tag), 33 + k);
            tick();
        end
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("full_end_valid", int'(alloc_valid), 0);
        check("full_end_ovf", int'(overflow_err), 1);

        // Vector table.
        reset_and_wait(1'b0, 0);
        foreach (tbl[i]) begin
            apply(tbl[i].req, tbl[i].fv, tbl[i].ft, tbl[i].sv, tbl[i].rs);
            check($sformatf("vec%0d_valid", i), int'(alloc_valid), int'(tbl[i].e_valid));
            if (tbl[i].chk_tag) check($sformatf("vec%0d_tag", i), int'(alloc_tag), int'(tbl[i].e_tag));
            check($sformatf("vec%0d_count", i), int'(free_count), tbl[i].e_count);
            check($sformatf("vec%0d_ovf", i), int'(overflow_err), int'(tbl[i].e_ovf));
            tick();
        end

        // Free during init is dropped; then reset mid-ready with 10 tags left.
        reset_and_wait(1'b1, 1);
        for (int k = 0; k < 22; k++) begin
            apply(1'b1, 1'b0, '0, 1'b0, 1'b0);
            check("initfree_tag", int'(alloc_tag), 32 + k);
            tick();
        end
        apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
        check("midreset_pre_count", int'(free_count), 10);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        reset_and_wait(1'b0, 0);

        // Random traffic against the queue model.
        q.delete();
        spec.delete();
        for (int t = ARCH_REGS; t < PHYS_REGS; t++) q.push_back(tag_t'(t));
        m_ovf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic r, f, s, x, acc, exp_valid, full_now;
            tag_t ft;
            int   req_pct;
            req_pct = ((c / 200) % 2 == 0) ? 70 : 30;
            r  = ($urandom_range(0, 99) < req_pct);
            f  = ($urandom_range(0, 9) < 4);
            ft = tag_t'($urandom);
            s  = ($urandom_range(0, 9) == 0);
            x  = ($urandom_range(0, 19) == 0);
            full_now = (q.size() == CAP);
            acc = f && !full_now;
            if (x && (spec.size() + q.size() + (acc ? 1 : 0) > CAP)) x = 1'b0;

            apply(r, f, ft, s, x);
            exp_valid = (q.size() != 0) && !x;
            check("rnd_ready", int'(ready), 1);
            check("rnd_valid", int'(alloc_valid), int'(exp_valid));
            check("rnd_count", int'(free_count), q.size());
            check("rnd_ovf", int'(overflow_err), int'(m_ovf));
            if (exp_valid) check("rnd_tag", int'(alloc_tag), int'(q[0]));
            tick();

            if (x) begin
                for (int i = spec.size() - 1; i >= 0; i--) q.push_front(spec[i]);
                spec.delete();
            end else begin
                if (r && exp_valid) spec.push_back(q.pop_front());
                if (s) spec.delete();
            end
            if (f) begin
                if (!full_now) q.push_back(ft);
                else m_ovf = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
